// File: rtl/islem_sirali_denetleyici_pkg.sv
// ---------------------------------------------------------------------------
// islem_paket
//   Shared definitions for the operation sequencer between the calculator
//   front end and its arithmetic units.
//   - TUR_* : operation codes, one per arithmetic unit (unit index == code)
//   - durum_t : sequencer state encoding (2-bit)
//   - *_VARSAYILAN : default parameter values
//   - SAYAC_W : width of the optional wait-timeout counter
// ---------------------------------------------------------------------------
package islem_paket;

    localparam int VERI_W_VARSAYILAN       = 32;
    localparam int BIRIM_SAYISI_VARSAYILAN = 4;
    localparam int ZAMAN_ASIMI_VARSAYILAN  = 16;
    localparam int SAYAC_W                 = 8;

    localparam logic [2:0] TUR_TOPLAMA = 3'd0;
    localparam logic [2:0] TUR_CIKARMA = 3'd1;
    localparam logic [2:0] TUR_CARPMA  = 3'd2;
    localparam logic [2:0] TUR_BOLME   = 3'd3;

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        BASLAT = 2'd1,
        BEKLE  = 2'd2,
        SONUC  = 2'd3
    } durum_t;

endpackage

// File: rtl/islem_sirali_denetleyici_zaman_sayaci.sv
// ---------------------------------------------------------------------------
// islem_zaman_sayaci
//   Wait-timeout counter for the sequencer's BEKLE state. Only instantiated
//   when ISLEM_ZAMAN_ASIMI_EN is defined.
//   clk       in  clock, rising edge
//   rst_n     in  synchronous active-low reset
//   i_temizle in  clear the count (asserted on the cycle before BEKLE)
//   i_etkin   in  count this cycle (high while in BEKLE)
//   i_sinir   in  limit; o_doldu marks the counting cycle that reaches it
//   o_doldu   out high in the cycle whose edge brings the count to i_sinir
// ---------------------------------------------------------------------------
module islem_zaman_sayaci
    import islem_paket::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_temizle,
    input  logic               i_etkin,
    input  logic [SAYAC_W-1:0] i_sinir,
    output logic               o_doldu
);

    logic [SAYAC_W-1:0] r_sayac;

    always_ff @(posedge clk) begin
        if (!rst_n || i_temizle) begin
            r_sayac <= '0;
        end else if (i_etkin) begin
            r_sayac <= r_sayac + 1'b1;
        end
    end

    // Look-ahead compare so the sequencer leaves BEKLE on the same edge
    // that the count reaches the limit.
    assign o_doldu = i_etkin && ((r_sayac + 1'b1) == i_sinir);

endmodule

// File: rtl/islem_sirali_denetleyici.sv
// ---------------------------------------------------------------------------
// islem_sirali_denetleyici
//   Sequencer between the calculator front end and the arithmetic units.
//   Accepts one request, starts the unit selected by istek_tur, waits for
//   that unit's gecerli, registers its 2*VERI_W result and overflow flag and
//   presents them to the consumer. One operation in flight at a time.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. istek_hazir is high only in BOS; gecerli is high only in
//   SONUC and sonuc/tasma/hata stay stable until the transfer edge.
//
//   Optional feature: define ISLEM_ZAMAN_ASIMI_EN to abort BEKLE after
//   ZAMAN_ASIMI cycles with hata=1 (adds the ZAMAN_ASIMI parameter).
//
//   Ports
//     clk, rst_n            clock / synchronous active-low reset
//     istek_gecerli/hazir   request handshake
//     istek_sayi1/2, _tur   request operands and operation code
//     birim_sayi1/2, _tur   registered operands broadcast to all units
//     birim_baslat          one-hot, one-cycle start pulse
//     birim_sonuc/_tasma/_gecerli  per-unit results (unit k at slice k)
//     sonuc, tasma, hata    registered result, overflow, error
//     gecerli, sonuc_hazir  result handshake
//     islem_sayaci          completed result handshakes, wraps
// ---------------------------------------------------------------------------
module islem_sirali_denetleyici
    import islem_paket::*;
#(
    parameter int VERI_W       = VERI_W_VARSAYILAN,
    parameter int BIRIM_SAYISI = BIRIM_SAYISI_VARSAYILAN
`ifdef ISLEM_ZAMAN_ASIMI_EN
   ,parameter int ZAMAN_ASIMI  = ZAMAN_ASIMI_VARSAYILAN
`endif
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           istek_gecerli,
    output logic                           istek_hazir,
    input  logic [VERI_W-1:0]              istek_sayi1,
    input  logic [VERI_W-1:0]              istek_sayi2,
    input  logic [2:0]                     istek_tur,
    output logic [VERI_W-1:0]              birim_sayi1,
    output logic [VERI_W-1:0]              birim_sayi2,
    output logic [2:0]                     birim_tur,
    output logic [BIRIM_SAYISI-1:0]        birim_baslat,
    input  logic [BIRIM_SAYISI*2*VERI_W-1:0] birim_sonuc,
    input  logic [BIRIM_SAYISI-1:0]        birim_tasma,
    input  logic [BIRIM_SAYISI-1:0]        birim_gecerli,
    output logic [2*VERI_W-1:0]            sonuc,
    output logic                           tasma,
    output logic                           hata,
    output logic                           gecerli,
    input  logic                           sonuc_hazir,
    output logic [15:0]                    islem_sayaci
);

    durum_t              r_durum;
    durum_t              w_sonraki;
    logic [VERI_W-1:0]   r_sayi1;
    logic [VERI_W-1:0]   r_sayi2;
    logic [2:0]          r_tur;
    logic [2*VERI_W-1:0] r_sonuc;
    logic                r_tasma;
    logic                r_hata;
    logic [15:0]         r_islem_sayaci;

    logic                w_kabul;
    logic                w_tur_gecerli;
    logic                w_teslim;
    logic                w_sec_gecerli;
    logic                w_sec_tasma;
    logic [2*VERI_W-1:0] w_sec_sonuc;
    logic                w_zaman_doldu;

    assign w_kabul       = (r_durum == BOS) && istek_gecerli;
    assign w_tur_gecerli = int'(istek_tur) < BIRIM_SAYISI;
    assign w_teslim      = (r_durum == SONUC) && sonuc_hazir;

    // Only the selected unit's signals are looked at; everything else on
    // the shared result bus is ignored.
    always_comb begin
        w_sec_gecerli = 1'b0;
        w_sec_tasma   = 1'b0;
        w_sec_sonuc   = '0;
        for (int k = 0; k < BIRIM_SAYISI; k++) begin
            if (int'(r_tur) == k) begin
                w_sec_gecerli = birim_gecerli[k];
                w_sec_tasma   = birim_tasma[k];
                w_sec_sonuc   = birim_sonuc[k*2*VERI_W +: 2*VERI_W];
            end
        end
    end

`ifdef ISLEM_ZAMAN_ASIMI_EN
    islem_zaman_sayaci u_zaman_sayaci (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_temizle (r_durum == BASLAT),
        .i_etkin   (r_durum == BEKLE),
        .i_sinir   (SAYAC_W'(ZAMAN_ASIMI)),
        .o_doldu   (w_zaman_doldu)
    );
`else
    assign w_zaman_doldu = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_durum <= BOS;
        end else begin
            r_durum <= w_sonraki;
        end
    end

    // Next-state logic
    always_comb begin
        w_sonraki = r_durum;
        case (r_durum)
            BOS:    if (istek_gecerli) w_sonraki = w_tur_gecerli ? BASLAT : SONUC;
            BASLAT: w_sonraki = BEKLE;
            BEKLE:  if (w_sec_gecerli || w_zaman_doldu) w_sonraki = SONUC;
            SONUC:  if (sonuc_hazir) w_sonraki = BOS;
            default: w_sonraki = BOS;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        istek_hazir  = (r_durum == BOS);
        gecerli      = (r_durum == SONUC);
        birim_baslat = '0;
        for (int k = 0; k < BIRIM_SAYISI; k++) begin
            birim_baslat[k] = (r_durum == BASLAT) && (int'(r_tur) == k);
        end
    end

    // Operand, result and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sayi1        <= '0;
            r_sayi2        <= '0;
            r_tur          <= '0;
            r_sonuc        <= '0;
            r_tasma        <= 1'b0;
            r_hata         <= 1'b0;
            r_islem_sayaci <= '0;
        end else begin
            if (w_kabul) begin
                r_sayi1 <= istek_sayi1;
                r_sayi2 <= istek_sayi2;
                r_tur   <= istek_tur;
                if (!w_tur_gecerli) begin
                    r_sonuc <= '0;
                    r_tasma <= 1'b0;
                    r_hata  <= 1'b1;
                end
            end
            if (r_durum == BEKLE) begin
                // A unit answer on the timeout edge still wins.
                if (w_sec_gecerli) begin
                    r_sonuc <= w_sec_sonuc;
                    r_tasma <= w_sec_tasma;
                    r_hata  <= 1'b0;
                end else if (w_zaman_doldu) begin
                    r_sonuc <= '0;
                    r_tasma <= 1'b0;
                    r_hata  <= 1'b1;
                end
            end
            if (w_teslim) begin
                r_islem_sayaci <= r_islem_sayaci + 16'd1;
            end
        end
    end

    assign birim_sayi1  = r_sayi1;
    assign birim_sayi2  = r_sayi2;
    assign birim_tur    = r_tur;
    assign sonuc        = r_sonuc;
    assign tasma        = r_tasma;
    assign hata         = r_hata;
    assign islem_sayaci = r_islem_sayaci;

endmodule

// File: tb/tb_islem_sirali_denetleyici.sv
// ---------------------------------------------------------------------------
// tb_islem_sirali_denetleyici
//   Directed bench for islem_sirali_denetleyici. Inputs change 1 time unit
//   after a rising edge and outputs are checked at the same point, so every
//   check sees the state produced by the preceding edge. The timeout case
//   runs only when ISLEM_ZAMAN_ASIMI_EN is defined.
// ---------------------------------------------------------------------------
module tb_islem_sirali_denetleyici;

    localparam int VW = 32;
    localparam int BS = 4;
    localparam int RW = 2 * VW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              istek_gecerli;
    logic              istek_hazir;
    logic [VW-1:0]     istek_sayi1;
    logic [VW-1:0]     istek_sayi2;
    logic [2:0]        istek_tur;
    logic [VW-1:0]     birim_sayi1;
    logic [VW-1:0]     birim_sayi2;
    logic [2:0]        birim_tur;
    logic [BS-1:0]     birim_baslat;
    logic [BS*RW-1:0]  birim_sonuc;
    logic [BS-1:0]     birim_tasma;
    logic [BS-1:0]     birim_gecerli;
    logic [RW-1:0]     sonuc;
    logic              tasma;
    logic              hata;
    logic              gecerli;
    logic              sonuc_hazir;
    logic [15:0]       islem_sayaci;

    integer n_vektor = 0;
    integer n_hata   = 0;
    integer n_kabul;

    islem_sirali_denetleyici dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .istek_gecerli (istek_gecerli),
        .istek_hazir   (istek_hazir),
        .istek_sayi1   (istek_sayi1),
        .istek_sayi2   (istek_sayi2),
        .istek_tur     (istek_tur),
        .birim_sayi1   (birim_sayi1),
        .birim_sayi2   (birim_sayi2),
        .birim_tur     (birim_tur),
        .birim_baslat  (birim_baslat),
        .birim_sonuc   (birim_sonuc),
        .birim_tasma   (birim_tasma),
        .birim_gecerli (birim_gecerli),
        .sonuc         (sonuc),
        .tasma         (tasma),
        .hata          (hata),
        .gecerli       (gecerli),
        .sonuc_hazir   (sonuc_hazir),
        .islem_sayaci  (islem_sayaci)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                           input logic [63:0] beklenen);
        n_vektor = n_vektor + 1;
        if (gozlenen !== beklenen) begin
            n_hata = n_hata + 1;
            $display("FAIL %s: got %0h expected %0h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic kenar();
        @(posedge clk);
        #1;
    endtask

    task automatic istek(input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [2:0] tur);
        istek_sayi1   = a;
        istek_sayi2   = b;
        istek_tur     = tur;
        istek_gecerli = 1'b1;
    endtask

    initial begin
        // Reset
        rst_n         = 1'b0;
        istek_gecerli = 1'b0;
        istek_sayi1   = '0;
        istek_sayi2   = '0;
        istek_tur     = '0;
        birim_sonuc   = '0;
        birim_tasma   = '0;
        birim_gecerli = '0;
        sonuc_hazir   = 1'b0;
        kenar();
        kenar();
        kontrol("rst_hazir",   64'(istek_hazir), 64'd1);
        kontrol("rst_gecerli", 64'(gecerli), 64'd0);
        kontrol("rst_baslat",  64'(birim_baslat), 64'd0);
        kontrol("rst_sayac",   64'(islem_sayaci), 64'd0);
        rst_n = 1'b1;
        kenar();

        // 1: 5 + 7, unit answers one cycle after the start pulse
        istek(32'd5, 32'd7, 3'd0);
        sonuc_hazir = 1'b1;
        kontrol("t1_hazir", 64'(istek_hazir), 64'd1);
        kenar();                                   // edge N: accept
        istek_gecerli = 1'b0;
        kontrol("t1_baslat", 64'(birim_baslat), 64'b0001);
        kontrol("t1_sayi1",  64'(birim_sayi1), 64'd5);
        kontrol("t1_sayi2",  64'(birim_sayi2), 64'd7);
        kontrol("t1_mesgul", 64'(istek_hazir), 64'd0);
        kenar();                                   // N+1: BEKLE
        kontrol("t1_baslat_dus", 64'(birim_baslat), 64'd0);
        kontrol("t1_gec_erken",  64'(gecerli), 64'd0);
        birim_sonuc[0 +: RW]  = 64'd12;
        birim_sonuc[RW +: RW] = 64'd99;
        birim_tasma   = 4'b1110;
        birim_gecerli = 4'b0001;
        kenar();                                   // N+2: captured
        birim_gecerli = 4'b0000;
        kontrol("t1_gecerli", 64'(gecerli), 64'd1);
        kontrol("t1_sonuc",   sonuc, 64'd12);
        kontrol("t1_tasma",   64'(tasma), 64'd0);
        kontrol("t1_hata",    64'(hata), 64'd0);
        kenar();                                   // N+3: handshake
        kontrol("t1_bos",   64'(istek_hazir), 64'd1);
        kontrol("t1_sayac", 64'(islem_sayaci), 64'd1);

        // 2: invalid tur, consumer stalls for five cycles
        istek(32'd3, 32'd4, 3'd6);
        sonuc_hazir = 1'b0;
        kenar();                                   // N: accept, straight to SONUC
        istek(32'd1, 32'd1, 3'd0);                 // must be ignored while busy
        kontrol("t2_baslat", 64'(birim_baslat), 64'd0);
        for (int i = 0; i < 5; i++) begin
            kontrol("t2_gecerli", 64'(gecerli), 64'd1);
            kontrol("t2_hata",    64'(hata), 64'd1);
            kontrol("t2_sonuc",   sonuc, 64'd0);
            kontrol("t2_hazir",   64'(istek_hazir), 64'd0);
            kenar();
        end
        istek_gecerli = 1'b0;
        sonuc_hazir   = 1'b1;
        kenar();
        kontrol("t2_bos",   64'(istek_hazir), 64'd1);
        kontrol("t2_tur",   64'(birim_tur), 64'd6);
        kontrol("t2_sayac", 64'(islem_sayaci), 64'd2);

        // 3: overflow add; other units' gecerli pulses are ignored
        istek(32'hFFFF_FFFF, 32'd1, 3'd0);
        sonuc_hazir = 1'b0;
        kenar();                                   // N
        istek(32'h0000_1234, 32'd9, 3'd2);         // held valid while busy
        birim_sonuc[0 +: RW]    = 64'h1_0000_0000;
        birim_sonuc[RW +: RW]   = 64'hDEAD;
        birim_sonuc[2*RW +: RW] = 64'hBEEF;
        birim_tasma = 4'b0001;
        kenar();                                   // N+1: BEKLE
        birim_gecerli = 4'b1110;
        kenar();
        kontrol("t3_yoksay1", 64'(gecerli), 64'd0);
        kenar();
        kontrol("t3_yoksay2", 64'(gecerli), 64'd0);
        kontrol("t3_sayi1",   64'(birim_sayi1), 64'hFFFF_FFFF);
        birim_gecerli = 4'b0001;
        kenar();
        birim_gecerli = 4'b0000;
        istek_gecerli = 1'b0;
        kontrol("t3_gecerli", 64'(gecerli), 64'd1);
        kontrol("t3_sonuc",   sonuc, 64'h1_0000_0000);
        kontrol("t3_tasma",   64'(tasma), 64'd1);
        sonuc_hazir = 1'b1;
        kenar();
        kontrol("t3_sayac", 64'(islem_sayaci), 64'd3);

        // 4: reset while waiting on a unit
        istek(32'd9, 32'd4, 3'd1);
        kenar();                                   // N
        istek_gecerli = 1'b0;
        kenar();                                   // N+1: BEKLE
        kenar();                                   // still BEKLE
        rst_n = 1'b0;
        kenar();
        kontrol("t4_hazir",   64'(istek_hazir), 64'd1);
        kontrol("t4_gecerli", 64'(gecerli), 64'd0);
        kontrol("t4_sonuc",   sonuc, 64'd0);
        kontrol("t4_tasma",   64'(tasma), 64'd0);
        kontrol("t4_sayi1",   64'(birim_sayi1), 64'd0);
        kontrol("t4_tur",     64'(birim_tur), 64'd0);
        kontrol("t4_sayac",   64'(islem_sayaci), 64'd0);
        rst_n = 1'b1;
        birim_sonuc[RW +: RW] = 64'd5;
        birim_gecerli = 4'b0010;                   // stale answer
        kenar();
        kenar();
        kenar();
        kontrol("t4_bayat_gec", 64'(gecerli), 64'd0);
        kontrol("t4_bayat_baslat", 64'(birim_baslat), 64'd0);
        birim_gecerli = 4'b0000;

        // 6: request held valid, consumer always ready; one accept per op.
        // Invalid tur gives a two-cycle round trip: 400 edges = 200 ops.
        istek(32'd1, 32'd2, 3'd7);
        sonuc_hazir = 1'b1;
        n_kabul = 0;
        for (int i = 0; i < 400; i++) begin
            if (istek_hazir && istek_gecerli) n_kabul = n_kabul + 1;
            kenar();
        end
        istek_gecerli = 1'b0;
        kontrol("t6_kabul", 64'(n_kabul), 64'd200);
        kontrol("t6_sayac", 64'(islem_sayaci), 64'd200);
        kontrol("t6_bos",   64'(istek_hazir), 64'd1);

`ifdef ISLEM_ZAMAN_ASIMI_EN
        // 5: silent unit, abort after 16 BEKLE cycles
        sonuc_hazir = 1'b0;
        birim_sonuc[2*RW +: RW] = 64'h77;
        istek(32'd6, 32'd7, 3'd2);
        kenar();                                   // N
        istek_gecerli = 1'b0;
        for (int i = 0; i < 16; i++) kenar();      // N+1 .. N+16
        kontrol("t5_erken", 64'(gecerli), 64'd0);
        kenar();                                   // N+17: 16th BEKLE edge
        kontrol("t5_gecerli", 64'(gecerli), 64'd1);
        kontrol("t5_hata",    64'(hata), 64'd1);
        kontrol("t5_sonuc",   sonuc, 64'd0);
        birim_gecerli = 4'b0100;                   // late answer
        kenar();
        birim_gecerli = 4'b0000;
        kontrol("t5_gec_sonuc", sonuc, 64'd0);
        kontrol("t5_gec_hata",  64'(hata), 64'd1);
        sonuc_hazir = 1'b1;
        kenar();
        kontrol("t5_bos", 64'(istek_hazir), 64'd1);
`endif

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", n_vektor, n_hata);
        $finish;
    end

endmodule
